// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter: m0 has fixed priority, m1 is forced through after STARVE_LIMIT lost arbitrations.
// Define ARB_PERF_CNT_EN to build the per-master grant counters; otherwise the counter ports read as zero.
module data_bus_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_be,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_be,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           m0_grant_cnt,
  output logic [31:0]           m1_grant_cnt
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_W = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q;
  logic          gnt_m1_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          any_req_s;
  logic          win_m1_s;

  // Arbitration winner and next starvation count, meaningful only while IDLE.
  always_comb begin
    any_req_s = m0_req | m1_req;
    win_m1_s  = 1'b0;
    starve_d  = starve_q;
    if (m1_req && !m0_req) begin
      win_m1_s = 1'b1;
    end else if (m1_req && m0_req && (STARVE_LIMIT != 0) && (starve_q >= LIMIT_W)) begin
      win_m1_s = 1'b1;
    end else begin
      win_m1_s = 1'b0;
    end
    if (!m1_req || win_m1_s) begin
      starve_d = {SW{1'b0}};
    end else if (m0_req) begin
      starve_d = (starve_q >= LIMIT_W) ? starve_q : starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Transaction FSM; every bus-facing output is a flop so reset clears it immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_m1_q  <= 1'b0;
      starve_q  <= {SW{1'b0}};
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= {DATA_WIDTH{1'b0}};
      m1_rdata  <= {DATA_WIDTH{1'b0}};
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= {DATA_WIDTH{1'b0}};
      mem_be    <= 4'd0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          starve_q <= starve_d;
          if (any_req_s) begin
            gnt_m1_q  <= win_m1_s;
            mem_addr  <= win_m1_s ? m1_addr  : m0_addr;
            mem_wdata <= win_m1_s ? m1_wdata : m0_wdata;
            mem_be    <= win_m1_s ? m1_be    : m0_be;
            mem_wr_en <= win_m1_s ? m1_we    : m0_we;
            mem_rd_en <= win_m1_s ? !m1_we   : !m0_we;
            state_q   <= ACCESS;
          end else begin
            state_q   <= IDLE;
          end
        end
        ACCESS: begin
          if (mem_rd_en && gnt_m1_q) begin
            m1_rdata <= mem_rdata;
          end else if (mem_rd_en) begin
            m0_rdata <= mem_rdata;
          end
          m0_ack    <= !gnt_m1_q;
          m1_ack    <= gnt_m1_q;
          mem_addr  <= {ADDR_WIDTH{1'b0}};
          mem_wdata <= {DATA_WIDTH{1'b0}};
          mem_be    <= 4'd0;
          mem_wr_en <= 1'b0;
          mem_rd_en <= 1'b0;
          state_q   <= RESP;
        end
        RESP: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          mem_addr  <= {ADDR_WIDTH{1'b0}};
          mem_wdata <= {DATA_WIDTH{1'b0}};
          mem_be    <= 4'd0;
          mem_wr_en <= 1'b0;
          mem_rd_en <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] m0_cnt_q;
  logic [31:0] m1_cnt_q;

  // Grant counters advance on the IDLE->ACCESS edge and wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_cnt_q <= 32'd0;
      m1_cnt_q <= 32'd0;
    end else if ((state_q == IDLE) && any_req_s) begin
      if (win_m1_s) begin
        m1_cnt_q <= m1_cnt_q + 32'd1;
      end else begin
        m0_cnt_q <= m0_cnt_q + 32'd1;
      end
    end
  end

  assign m0_grant_cnt = m0_cnt_q;
  assign m1_grant_cnt = m1_cnt_q;
`else
  assign m0_grant_cnt = 32'd0;
  assign m1_grant_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench: stimulus queues expected bus cycles and acks, negedge monitors pop and compare.
// A second instance with STARVE_LIMIT = 0 shares all inputs to check strict m0 priority.
module tb_data_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;

  logic        m0_ack, m1_ack, mem_wr_en, mem_rd_en;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata, m0_grant_cnt, m1_grant_cnt;
  logic [3:0]  mem_be;

  logic        s_m0_ack, s_m1_ack, s_mem_wr_en, s_mem_rd_en;
  logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata, s_m0_grant_cnt, s_m1_grant_cnt;
  logic [3:0]  s_mem_be;

  typedef struct { logic m1; logic [31:0] rdata; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    total = 0;
  int    bad = 0;
  int    s_m0_n = 0;
  int    s_m1_n = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h1000_0010) ? 32'hDEAD_BEEF : ~a;
  endfunction

  assign mem_rdata   = rd_model(mem_addr);
  assign s_mem_rdata = rd_model(s_mem_addr);

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt)
  );

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(0)) dut_strict (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(s_m0_ack), .m0_rdata(s_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(s_m1_ack), .m1_rdata(s_m1_rdata),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_be(s_mem_be),
    .mem_wr_en(s_mem_wr_en), .mem_rd_en(s_mem_rd_en), .mem_rdata(s_mem_rdata),
    .m0_grant_cnt(s_m0_grant_cnt), .m1_grant_cnt(s_m1_grant_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ack monitor: exclusivity, winner identity and read data.
  always @(negedge clk) begin : mon_resp
    resp_t r;
    if (rst && (m0_ack || m1_ack)) begin
      check("ack_excl", 32'(m0_ack & m1_ack), 32'd0);
      if (resp_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        r = resp_q.pop_front();
        check("ack_master", 32'(m1_ack), 32'(r.m1));
        check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, r.rdata);
      end
    end
    if (rst && s_m0_ack) s_m0_n++;
    if (rst && s_m1_ack) s_m1_n++;
  end

  // Bus monitor: every strobe cycle must match the next expected access.
  always @(negedge clk) begin : mon_bus
    bus_t b;
    if (rst && (mem_wr_en || mem_rd_en)) begin
      check("strobe_excl", 32'(mem_wr_en & mem_rd_en), 32'd0);
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 32'd1, 32'd0);
      end else begin
        b = bus_q.pop_front();
        check("bus_we", 32'(mem_wr_en), 32'(b.we));
        check("bus_addr", mem_addr, b.addr);
        check("bus_wdata", mem_wdata, b.wdata);
        check("bus_be", 32'(mem_be), 32'(b.be));
      end
    end
  end

  task automatic wait_acks(input int n, output int cyc);
    int got = 0;
    cyc = 0;
    while (got < n && cyc < 30 * n) begin
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) got++;
    end
    if (got < n) check("ack_timeout", 32'(got), 32'(n));
  endtask

  task automatic run_m(input bit m1, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input string nm);
    int cyc;
    @(negedge clk);
    bus_q.push_back('{we, addr, wdata, be});
    resp_q.push_back('{m1, exp_rd});
    if (m1) begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_req = 1'b1;
    end
    wait_acks(1, cyc);
    check(nm, 32'(cyc), 32'd2);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ack_seen;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0020; m0_wdata = 32'h0000_0000; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0300_0000; m1_wdata = 32'hCAFE_F00D; m1_be = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("rst_quiet", 32'({m0_ack, m1_ack, mem_wr_en, mem_rd_en, s_m0_ack, s_m1_ack}), 32'd0);
      check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) begin
        bus_q.push_back('{1'b1, 32'h0300_0000, 32'hCAFE_F00D, 4'hF});
        resp_q.push_back('{1'b1, 32'h0000_0000});
      end else begin
        bus_q.push_back('{1'b0, 32'h1000_0020, 32'h0000_0000, 4'hF});
        resp_q.push_back('{1'b0, 32'hEFFF_FFDF});
      end
    end
    rst = 1'b1;
    wait_acks(1, cyc);
    check("first_ack_lat", 32'(cyc), 32'd2);
    wait_acks(19, cyc);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    check("strict_m1_never", 32'(s_m1_n), 32'd0);
    check("strict_m0_all", 32'(s_m0_n), 32'd20);
`ifdef ARB_PERF_CNT_EN
    check("cnt_m0_contention", m0_grant_cnt, 32'd16);
    check("cnt_m1_contention", m1_grant_cnt, 32'd4);
`else
    check("cnt_m0_tied", m0_grant_cnt, 32'd0);
    check("cnt_m1_tied", m1_grant_cnt, 32'd0);
`endif

    run_m(1'b0, 1'b0, 32'h1000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, "m0_rd_lat");
    run_m(1'b1, 1'b0, 32'h0200_0100, 32'h0000_0000, 4'hF, 32'hFDFF_FEFF, "m1_rd_lat");
    run_m(1'b1, 1'b1, 32'h0200_4000, 32'h1234_5678, 4'b0011, 32'hFDFF_FEFF, "m1_wr_lat");
    run_m(1'b0, 1'b1, 32'h1000_0044, 32'hA5A5_5A5A, 4'b1100, 32'hDEAD_BEEF, "m0_wr_lat");

    // Request withdrawn while the access is in flight still completes.
    @(negedge clk);
    bus_q.push_back('{1'b1, 32'h1000_0050, 32'h0BAD_F00D, 4'b0001});
    resp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    m0_we = 1'b1; m0_addr = 32'h1000_0050; m0_wdata = 32'h0BAD_F00D; m0_be = 4'b0001; m0_req = 1'b1;
    @(negedge clk);
    m0_req = 1'b0;
    wait_acks(1, cyc);
    check("drop_lat", 32'(cyc), 32'd1);

    // Reset during ACCESS of an m0 write, then restart with the request still held.
    @(negedge clk);
    bus_q.push_back('{1'b1, 32'h1000_0060, 32'h5555_AAAA, 4'hF});
    m0_we = 1'b1; m0_addr = 32'h1000_0060; m0_wdata = 32'h5555_AAAA; m0_be = 4'hF; m0_req = 1'b1;
    @(negedge clk);
    check("access_wr_en", 32'(mem_wr_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_wr", 32'(mem_wr_en), 32'd0);
    check("rst_async_addr", mem_addr, 32'd0);
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack || m1_ack) ack_seen++;
    end
    check("rst_no_ack", 32'(ack_seen), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    bus_q.push_back('{1'b1, 32'h1000_0060, 32'h5555_AAAA, 4'hF});
    resp_q.push_back('{1'b0, 32'h0000_0000});
    rst = 1'b1;
    wait_acks(1, cyc);
    check("restart_lat", 32'(cyc), 32'd2);
    m0_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
    check("cnt_m0_restart", m0_grant_cnt, 32'd1);
`else
    check("cnt_m0_restart", m0_grant_cnt, 32'd0);
`endif
    check("cnt_m1_restart", m1_grant_cnt, 32'd0);

    repeat (4) @(negedge clk);
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
